alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//   Shares one combinational 32-bit ALU (ADD/SUB/SHL/SHR, 2-bit opcode) between NUM_REQ requesters.
//   Round-robin arbiter plus a 3-state sequencer: accept, drive ALU, return tagged result.
//   Sits between issuing units and the single ALU instance. Only this block drives alu_a/alu_b/alu_op.
// PARAMETERS
//   NUM_REQ  4   number of requesters, 2..8
//   DATA_W   32  operand/result width; must match the ALU
//   ID_W     3   width of resp_id; must satisfy 2**ID_W >= NUM_REQ
// PORTS
//   clk         in   1                clock, rising edge
//   rst_n       in   1                asynchronous active-low reset
//   req_valid   in   NUM_REQ          per-requester request valid
//   req_ready   out  NUM_REQ          one-hot accept; a request is taken when valid&ready
//   req_a       in   NUM_REQ*DATA_W   operand A, requester i at [i*DATA_W +: DATA_W]
//   req_b       in   NUM_REQ*DATA_W   operand B, same packing
//   req_op      in   NUM_REQ*2        opcode: 00 add, 01 sub, 10 shl, 11 shr
//   alu_a       out  DATA_W           to ALU InputA
//   alu_b       out  DATA_W           to ALU InputB
//   alu_op      out  2                to ALU Sopcode
//   alu_result  in   DATA_W           from ALU Result (combinational)
//   resp_valid  out  1                result available
//   resp_ready  in   1                consumer accepts result
//   resp_id     out  ID_W             index of the requester that owns resp_data
//   resp_data   out  DATA_W           registered ALU result
//   op_count    out  16               completed ops (ALU_ARB_STATS_EN only)
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, rr pointer 0, op_count 0. Reset acts immediately; any in-flight op is dropped.
//   Reset hazard: requester 0 sees req_ready=0 throughout reset.
//   FSM IDLE -> EXEC -> RESP -> IDLE.
//   IDLE:
//     req_ready is one-hot to the first requester with valid high, searching from the rr pointer upward with wrap.
//     req_ready is combinational from req_valid and the rr pointer, and is 0 in all other states.
//     On a handshake: latch a/b/op/id into regs, set rr = (granted + 1) mod NUM_REQ, go to EXEC.
//   EXEC: alu_* driven from the latched regs. At the clock edge, capture alu_result into resp_data, set resp_valid=1, go to RESP.
//   RESP: hold resp_valid, resp_id and resp_data stable until resp_valid&resp_ready, then resp_valid=0 and go to IDLE.
//   Outside EXEC, alu_* hold their last latched values. The ALU input never toggles without a request.
//   Latency: handshake in cycle N -> resp_valid high in cycle N+2. Throughput is at most 1 op per 3 cycles.
//   Arithmetic is the ALU's own. Add/sub wrap mod 2**DATA_W. Shift amount is the full B, so B>=DATA_W gives 0.
//   Operands pass through unmodified.
//   Simultaneous requests: rr order only. Requesters not granted keep valid and their operands stable (AXI-style).
//   A requester never gets a second grant while another valid requester is waiting.
//   resp_ready held low: the FSM stalls in RESP with no further grants and no loss.
//   resp_ready high in the same cycle resp_valid rises: transfer completes at that edge.
//   rr pointer only advances on a grant.
// CONFIGURATION
//   ALU_ARB_STATS_EN defined:
//     op_count increments on each resp handshake and saturates at 16'hFFFF.
//     Cleared only by reset.
//   ALU_ARB_STATS_EN undefined: op_count is tied to 0 and no counter flops exist.
// STRUCTURE
//   Package alu_arb_pkg holds:
//     ALU_OP_ADD=2'b00, ALU_OP_SUB=2'b01, ALU_OP_SHL=2'b10, ALU_OP_SHR=2'b11
//     state_t enum {IDLE, EXEC, RESP}
//   Sub-module rr_arbiter (NUM_REQ) maps (valid vector, pointer) -> one-hot grant plus index.
//   The ALU stays outside this block; the top level connects it.
// TESTING
//   Single op: req 2 valid, a=5, b=7, op=00 -> req_ready[2] in cycle 0; resp_valid in cycle 2 with resp_id=2, resp_data=12.
//   Contention: all 4 valid from reset -> grant order 0,1,2,3,0. Each result tagged correctly. No grant while in EXEC/RESP.
//   Edge arithmetic:
//     sub 0-1 -> 32'hFFFFFFFF
//     shl 1<<31 -> 32'h80000000
//     shr a, b=40 -> 0
//     add FFFFFFFF+1 -> 0
//   Backpressure: resp_ready low 10 cycles -> resp_data/resp_id stable, no req_ready. Release -> one transfer, back to IDLE.
//   Reset mid-op: rst_n low during EXEC -> all outputs 0 at once. After release, pending requests restart from requester 0.
//   Stats: with ALU_ARB_STATS_EN, 5 ops -> op_count=5. Force 16'hFFFF then 1 op -> stays 16'hFFFF. Without the macro -> always 0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Package: alu_arb_pkg
// Purpose: shared opcode encodings and sequencer state type for alu_arbiter.
// Contents:
//   ALU_OP_ADD/SUB/SHL/SHR  2-bit ALU opcode encodings
//   state_t                 sequencer states IDLE, EXEC, RESP
package alu_arb_pkg;

    localparam logic [1:0] ALU_OP_ADD = 2'b00;
    localparam logic [1:0] ALU_OP_SUB = 2'b01;
    localparam logic [1:0] ALU_OP_SHL = 2'b10;
    localparam logic [1:0] ALU_OP_SHR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_rr.sv
// Module: rr_arbiter
// Purpose: round-robin pick. Starting at ptr_i and wrapping, selects the
//          first requester whose valid bit is set.
// Ports:
//   valid_i  in   NUM_REQ   request valid vector
//   ptr_i    in   ID_W      search start index (0..NUM_REQ-1)
//   grant_o  out  NUM_REQ   one-hot grant (all zero if nothing valid)
//   idx_o    out  ID_W      index of the granted requester
//   any_o    out  1         some requester is valid
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 3
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    always_comb begin : pick
        int j;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr_i) + k) % NUM_REQ;
            if (!any_o && valid_i[j]) begin
                any_o      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Module: alu_arbiter
// Purpose: shares one external combinational ALU between NUM_REQ requesters.
//          Round-robin grant in IDLE, ALU driven from latched operands in
//          EXEC, tagged registered result held in RESP until accepted.
// Optional feature: define ALU_ARB_STATS_EN for a saturating 16-bit
//          completed-op counter on op_count; otherwise op_count is 0.
// Ports:
//   clk, rst_n              clock (rising), async active-low reset
//   req_valid/req_ready     per-requester handshake (ready one-hot)
//   req_a/req_b/req_op      packed per-requester operands/opcode
//   alu_a/alu_b/alu_op      to the ALU
//   alu_result              from the ALU (combinational)
//   resp_valid/resp_ready   result handshake
//   resp_id/resp_data       owner index and registered result
//   op_count                completed-op count (stats build only)
module alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*2-1:0]      req_op,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [1:0]                alu_op,
    input  logic [DATA_W-1:0]         alu_result,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [ID_W-1:0]           resp_id,
    output logic [DATA_W-1:0]         resp_data,
    output logic [15:0]               op_count
);

    import alu_arb_pkg::*;

    // state | meaning
    // IDLE  | offering a round-robin grant to the valid requesters
    // EXEC  | ALU driven from latched operands, result captured at the edge
    // RESP  | result held on resp_* until the consumer accepts it

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_q, rr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [1:0]          op_q, op_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                rv_q, rv_d;

    logic [NUM_REQ-1:0]  grant_vec;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_any;
    logic                resp_fire;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .valid_i (req_valid),
        .ptr_i   (rr_q),
        .grant_o (grant_vec),
        .idx_o   (grant_idx),
        .any_o   (grant_any)
    );

    // Gate with rst_n so no requester sees a grant while reset is held.
    assign req_ready  = (state_q == IDLE && rst_n) ? grant_vec : '0;
    assign resp_fire  = (state_q == RESP) && resp_ready;

    // ALU inputs come straight from the latch, so they only move on a grant.
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;
    assign resp_valid = rv_q;
    assign resp_id    = id_q;
    assign resp_data  = data_q;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        data_d  = data_q;
        rv_d    = rv_q;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    a_d     = req_a[grant_idx*DATA_W +: DATA_W];
                    b_d     = req_b[grant_idx*DATA_W +: DATA_W];
                    op_d    = req_op[grant_idx*2 +: 2];
                    id_d    = grant_idx;
                    rr_d    = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0
                                                               : grant_idx + ID_W'(1);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                data_d  = alu_result;
                rv_d    = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    rv_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                rv_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= ALU_OP_ADD;
            data_q  <= '0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            data_q  <= data_d;
            rv_q    <= rv_d;
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [15:0] op_count_q, op_count_d;

    always_comb begin
        op_count_d = op_count_q;
        if (resp_fire && op_count_q != 16'hFFFF) begin
            op_count_d = op_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign op_count = op_count_q;
`else
    assign op_count = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: models the external ALU, drives directed
// request sequences and checks tagged results through a scoreboard queue.
module tb_alu_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a, req_b;
    logic [7:0]   req_op;
    logic [31:0]  alu_a, alu_b, alu_result;
    logic [1:0]   alu_op;
    logic         resp_valid, resp_ready;
    logic [2:0]   resp_id;
    logic [31:0]  resp_data;
    logic [15:0]  op_count;

    typedef struct {
        logic [2:0]  id;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          ptr_m  = 0;
    logic [31:0] ta[4];
    logic [31:0] tb_[4];
    logic [1:0]  to[4];

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a << b;
            default: return a >> b;
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_op);

    alu_arbiter #(.NUM_REQ(4), .DATA_W(32), .ID_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .op_count   (op_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply();
        for (int i = 0; i < 4; i++) begin
            req_a[i*32 +: 32] = ta[i];
            req_b[i*32 +: 32] = tb_[i];
            req_op[i*2 +: 2]  = to[i];
        end
    endtask

    function automatic int pick(input logic [3:0] mask, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (mask[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return 0;
    endfunction

    task automatic do_reset(input logic [3:0] mask);
        rst_n      = 1'b0;
        req_valid  = mask;
        resp_ready = 1'b1;
        #1;
        check("rst_req_ready", 32'(req_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_req_ready", 32'(req_ready), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_id", 32'(resp_id), 0);
        check("rst_op_count", 32'(op_count), 0);
        rst_n = 1'b1;
        ptr_m = 0;
        sb.delete();
    endtask

    task automatic expect_resp();
        int   n;
        exp_t e;
        n = 0;
        while (resp_valid !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        if (resp_valid !== 1'b1) begin
            check("resp_timeout", 32'(resp_valid), 1);
        end else if (sb.size() == 0) begin
            check("sb_unexpected_resp", 32'(resp_valid), 0);
        end else begin
            e = sb.pop_front();
            check("resp_id", 32'(resp_id), 32'(e.id));
            check("resp_data", resp_data, e.data);
        end
    endtask

    task automatic single_op(input int id, input logic [31:0] a, input logic [31:0] b,
                             input logic [1:0] op, input logic [31:0] exp);
        exp_t e;
        ta[id] = a; tb_[id] = b; to[id] = op;
        apply();
        req_valid = 4'(1 << id);
        e.id = 3'(id); e.data = exp;
        sb.push_back(e);
        #1;
        check("single_grant", 32'(req_ready), 32'(1 << id));
        cyc();
        req_valid = 4'b0000;
        ptr_m = (id + 1) % 4;
        #1;
        check("exec_resp_valid", 32'(resp_valid), 0);
        check("exec_req_ready", 32'(req_ready), 0);
        check("exec_alu_a", alu_a, a);
        check("exec_alu_b", alu_b, b);
        check("exec_alu_op", 32'(alu_op), 32'(op));
        cyc();
        check("lat_resp_valid", 32'(resp_valid), 1);
        expect_resp();
        cyc();
        check("after_resp_valid", 32'(resp_valid), 0);
        cyc();
        check("alu_a_hold", alu_a, a);
    endtask

    task automatic grant_step(input bit reload0, output int g);
        exp_t e;
        g = pick(req_valid, ptr_m);
        #1;
        check("rr_grant", 32'(req_ready), 32'(1 << g));
        e.id = 3'(g); e.data = alu_f(ta[g], tb_[g], to[g]);
        sb.push_back(e);
        cyc();
        ptr_m = (g + 1) % 4;
        if (g == 0 && reload0) begin
            ta[0] = 32'd1000; tb_[0] = 32'd1; to[0] = 2'b01;
            apply();
        end else begin
            req_valid[g] = 1'b0;
        end
        #1;
        check("exec_no_grant", 32'(req_ready), 0);
        cyc();
        check("resp_no_grant", 32'(req_ready), 0);
        check("resp_valid_lat", 32'(resp_valid), 1);
        expect_resp();
        cyc();
    endtask

    initial begin
        int g;
        int order5[5];
        int order3[3];
        exp_t e;
        order5 = '{0, 1, 2, 3, 0};
        order3 = '{0, 1, 3};
        for (int i = 0; i < 4; i++) begin
            ta[i] = 32'd10 * 32'(i + 1);
            tb_[i] = 32'(i + 3);
            to[i] = 2'(i);
        end
        req_a = '0; req_b = '0; req_op = '0;
        apply();

        // single op, latency and tagging
        do_reset(4'b0000);
        single_op(2, 32'd5, 32'd7, 2'b00, 32'd12);

        // edge arithmetic
        single_op(1, 32'd0, 32'd1, 2'b01, 32'hFFFF_FFFF);
        single_op(1, 32'd1, 32'd31, 2'b10, 32'h8000_0000);
        single_op(1, 32'h1234_5678, 32'd40, 2'b11, 32'h0000_0000);
        single_op(1, 32'hFFFF_FFFF, 32'd1, 2'b00, 32'h0000_0000);

        // contention from reset
        for (int i = 0; i < 4; i++) begin
            ta[i] = 32'd10 * 32'(i + 1); tb_[i] = 32'(i + 3); to[i] = 2'(i);
        end
        apply();
        do_reset(4'b1111);
        for (int k = 0; k < 5; k++) begin
            grant_step(k == 0, g);
            check("grant_order", 32'(g), 32'(order5[k]));
        end
        check("sb_drained", 32'(sb.size()), 0);

        // backpressure
        resp_ready = 1'b0;
        ta[3] = 32'd100; tb_[3] = 32'd23; to[3] = 2'b01;
        ta[1] = 32'd3;   tb_[1] = 32'd4;  to[1] = 2'b10;
        apply();
        req_valid = 4'b1000;
        e.id = 3'd3; e.data = 32'd77;
        sb.push_back(e);
        #1;
        check("bp_grant", 32'(req_ready), 32'b1000);
        cyc();
        req_valid = 4'b0010;
        cyc();
        for (int k = 0; k < 10; k++) begin
            check("bp_valid", 32'(resp_valid), 1);
            check("bp_id", 32'(resp_id), 3);
            check("bp_data", resp_data, 32'd77);
            check("bp_no_grant", 32'(req_ready), 0);
            cyc();
        end
        resp_ready = 1'b1;
        #1;
        expect_resp();
        cyc();
        check("bp_released", 32'(resp_valid), 0);
        ptr_m = 0;
        grant_step(1'b0, g);
        check("bp_next_grant", 32'(g), 1);

        // reset mid-op
        req_valid = 4'b1010;
        #1;
        check("mid_grant", 32'(req_ready), 32'b1000);
        cyc();
        rst_n = 1'b0;
        req_valid = 4'b1011;
        #1;
        check("mid_rst_req_ready", 32'(req_ready), 0);
        check("mid_rst_alu_a", alu_a, 0);
        check("mid_rst_alu_b", alu_b, 0);
        check("mid_rst_alu_op", 32'(alu_op), 0);
        check("mid_rst_resp_valid", 32'(resp_valid), 0);
        check("mid_rst_resp_id", 32'(resp_id), 0);
        check("mid_rst_resp_data", resp_data, 0);
        check("mid_rst_op_count", 32'(op_count), 0);
        cyc();
        check("mid_rst_hazard", 32'(req_ready), 0);
        cyc();
        rst_n = 1'b1;
        ptr_m = 0;
        sb.delete();
        for (int k = 0; k < 3; k++) begin
            grant_step(1'b0, g);
            check("restart_order", 32'(g), 32'(order3[k]));
        end

`ifdef ALU_ARB_STATS_EN
        check("stats_3", 32'(op_count), 3);
        single_op(0, 32'd2, 32'd2, 2'b00, 32'd4);
        single_op(2, 32'd9, 32'd4, 2'b01, 32'd5);
        check("stats_5", 32'(op_count), 5);
        force dut.op_count_q = 16'hFFFF;
        #1;
        release dut.op_count_q;
        cyc();
        check("stats_forced", 32'(op_count), 32'h0000_FFFF);
        single_op(3, 32'd1, 32'd1, 2'b00, 32'd2);
        check("stats_saturate", 32'(op_count), 32'h0000_FFFF);
`else
        check("stats_off_a", 32'(op_count), 0);
        single_op(0, 32'd2, 32'd2, 2'b00, 32'd4);
        check("stats_off_b", 32'(op_count), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
